// File: rtl/pwm_ramp_ctrl_if.sv
// pwm_ramp_ctrl_if
// Bundles the CPU register bus and the PWM-core side signals of pwm_ramp_ctrl.
//   master : CPU/PWM-core side (drives the bus strobes and period_end)
//   slave  : the controller (drives rdata and the pwm_* outputs and irq)
// Ports carried:
//   wr_en, rd_en, addr[1:0], wdata[31:0]  bus request
//   rdata[31:0]                            registered read data
//   period_end                             PWM counter wrap pulse
//   pwm_period, pwm_duty [W-1:0], pwm_load, pwm_enable, irq
interface pwm_ramp_ctrl_if #(
  parameter int W = 16
);
  logic         wr_en;
  logic         rd_en;
  logic [1:0]   addr;
  logic [31:0]  wdata;
  logic [31:0]  rdata;
  logic         period_end;
  logic [W-1:0] pwm_period;
  logic [W-1:0] pwm_duty;
  logic         pwm_load;
  logic         pwm_enable;
  logic         irq;

  modport master (
    output wr_en, rd_en, addr, wdata, period_end,
    input  rdata, pwm_period, pwm_duty, pwm_load, pwm_enable, irq
  );

  modport slave (
    input  wr_en, rd_en, addr, wdata, period_end,
    output rdata, pwm_period, pwm_duty, pwm_load, pwm_enable, irq
  );
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl
// Register-programmed sequencer for the PWM core. Either holds a manual duty
// or runs an up/hold/down/hold breathing ramp. Every change to the PWM core
// is committed on period_end (except enable/disable), so no partial cycles.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  pwm_ramp_ctrl_if.slave (register bus + PWM core signals)
// Registers: 0 CTRL {EN,MODE,ONESHOT}, 1 PERIOD, 2 DUTY (manual / ramp max),
//            3 STEP_HOLD {hold[31:16], step[W-1:0]}
// Optional: define PWM_RAMP_IRQ_EN to build the sticky sequence-done irq flag;
//           otherwise irq is tied low and CTRL[8] reads 0.
module pwm_ramp_ctrl #(
  parameter int W          = 16,
  parameter int PERIOD_RST = 1000
) (
  input logic           clk,
  input logic           rst,
  pwm_ramp_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MANUAL    = 3'd1,
    RAMP_UP   = 3'd2,
    HOLD_HI   = 3'd3,
    RAMP_DOWN = 3'd4,
    HOLD_LO   = 3'd5
  } state_t;

  // shadow registers
  logic [2:0]   ctrl_reg;
  logic [W-1:0] period_reg;
  logic [W-1:0] duty_reg;
  logic [W-1:0] step_reg;
  logic [15:0]  hold_reg;

  state_t       state_reg, state_next;
  logic [W-1:0] pwm_period_reg, pwm_period_next;
  logic [W-1:0] pwm_duty_reg, pwm_duty_next;
  logic         pwm_load_reg, pwm_load_next;
  logic         pwm_enable_reg, pwm_enable_next;
  logic [15:0]  hold_cnt_reg, hold_cnt_next;
  logic [31:0]  rdata_reg, rd_mux;
  logic         irq_flag_reg;
  logic         oneshot_done;

  logic wr_ctrl, en_rise, en_fall;
  assign wr_ctrl = bus.wr_en && (bus.addr == 2'd0);
  assign en_rise = wr_ctrl && !ctrl_reg[0] && bus.wdata[0];
  assign en_fall = wr_ctrl && ctrl_reg[0] && !bus.wdata[0];

  // Ramp arithmetic carries one extra bit so sums never wrap.
  logic [W:0] step_eff, max_eff, duty_ext, up_sum, up_val, down_val;
  logic       hold_done;
  assign step_eff  = (step_reg == '0) ? (W+1)'(1) : {1'b0, step_reg};
  assign max_eff   = (duty_reg < period_reg) ? {1'b0, duty_reg} : {1'b0, period_reg};
  assign duty_ext  = {1'b0, pwm_duty_reg};
  assign up_sum    = duty_ext + step_eff;
  assign up_val    = (up_sum >= max_eff) ? max_eff : up_sum;
  assign down_val  = (duty_ext > step_eff) ? (duty_ext - step_eff) : '0;
  // Hold exits once hold_reg full periods have been spent at the extreme;
  // hold=0 therefore leaves on the first period_end after arrival.
  assign hold_done = (hold_cnt_reg >= hold_reg);

  always_comb begin
    state_next      = state_reg;
    pwm_period_next = pwm_period_reg;
    pwm_duty_next   = pwm_duty_reg;
    pwm_load_next   = 1'b0;
    pwm_enable_next = pwm_enable_reg;
    hold_cnt_next   = hold_cnt_reg;
    oneshot_done    = 1'b0;
    if (en_fall) begin
      state_next      = IDLE;
      pwm_enable_next = 1'b0;
      pwm_duty_next   = '0;
      hold_cnt_next   = '0;
    end else if (en_rise) begin
      // Start immediately with the current shadow values; ramps start at 0.
      pwm_enable_next = 1'b1;
      pwm_load_next   = 1'b1;
      pwm_period_next = period_reg;
      pwm_duty_next   = bus.wdata[1] ? '0 : duty_reg;
      state_next      = bus.wdata[1] ? RAMP_UP : MANUAL;
      hold_cnt_next   = '0;
    end else if (bus.period_end && (state_reg != IDLE)) begin
      pwm_load_next   = 1'b1;
      pwm_period_next = period_reg;
      if (!ctrl_reg[1]) begin
        state_next    = MANUAL;
        pwm_duty_next = duty_reg;
        hold_cnt_next = '0;
      end else begin
        unique case (state_reg)
          MANUAL: begin
            // manual->ramp continues from whatever duty is on the pin
            state_next    = RAMP_UP;
            hold_cnt_next = '0;
          end
          RAMP_UP: begin
            pwm_duty_next = up_val[W-1:0];
            if (up_val == max_eff) begin
              state_next    = HOLD_HI;
              hold_cnt_next = '0;
            end
          end
          HOLD_HI: begin
            if (hold_done) begin
              pwm_duty_next = down_val[W-1:0];
              hold_cnt_next = '0;
              state_next    = (down_val == '0) ? HOLD_LO : RAMP_DOWN;
            end else begin
              hold_cnt_next = hold_cnt_reg + 16'd1;
            end
          end
          RAMP_DOWN: begin
            pwm_duty_next = down_val[W-1:0];
            if (down_val == '0) begin
              state_next    = HOLD_LO;
              hold_cnt_next = '0;
            end
          end
          HOLD_LO: begin
            if (hold_done) begin
              hold_cnt_next = '0;
              if (ctrl_reg[2]) begin
                state_next      = IDLE;
                pwm_enable_next = 1'b0;
                pwm_load_next   = 1'b0;
                pwm_period_next = pwm_period_reg;
                oneshot_done    = 1'b1;
              end else begin
                pwm_duty_next = up_val[W-1:0];
                state_next    = (up_val == max_eff) ? HOLD_HI : RAMP_UP;
              end
            end else begin
              hold_cnt_next = hold_cnt_reg + 16'd1;
            end
          end
          default: begin
            state_next      = IDLE;
            pwm_enable_next = 1'b0;
            pwm_load_next   = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      pwm_period_reg <= W'(PERIOD_RST);
      pwm_duty_reg   <= '0;
      pwm_load_reg   <= 1'b0;
      pwm_enable_reg <= 1'b0;
      hold_cnt_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      pwm_period_reg <= pwm_period_next;
      pwm_duty_reg   <= pwm_duty_next;
      pwm_load_reg   <= pwm_load_next;
      pwm_enable_reg <= pwm_enable_next;
      hold_cnt_reg   <= hold_cnt_next;
    end
  end

  // Shadow registers. A finished one-shot self-clears EN so that software
  // re-arms it with an ordinary 0->1 write; done beats a same-cycle EN write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_reg   <= '0;
      period_reg <= W'(PERIOD_RST);
      duty_reg   <= '0;
      step_reg   <= '0;
      hold_reg   <= '0;
    end else begin
      if (wr_ctrl) begin
        ctrl_reg <= {bus.wdata[2:1], bus.wdata[0] & ~oneshot_done};
      end else if (oneshot_done) begin
        ctrl_reg[0] <= 1'b0;
      end
      if (bus.wr_en) begin
        unique case (bus.addr)
          2'd1: period_reg <= bus.wdata[W-1:0];
          2'd2: duty_reg   <= bus.wdata[W-1:0];
          2'd3: begin
            step_reg <= bus.wdata[W-1:0];
            hold_reg <= bus.wdata[31:16];
          end
          default: ;
        endcase
      end
    end
  end

`ifdef PWM_RAMP_IRQ_EN
  // Sticky done flag; a set in the same cycle as a software clear wins.
  logic irq_set;
  assign irq_set = oneshot_done ||
                   ((state_next == HOLD_LO) && (state_reg != HOLD_LO) && !ctrl_reg[2]);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          irq_flag_reg <= 1'b0;
    else if (irq_set)                 irq_flag_reg <= 1'b1;
    else if (wr_ctrl && bus.wdata[8]) irq_flag_reg <= 1'b0;
  end
`else
  assign irq_flag_reg = 1'b0;
`endif

  logic [15:0] duty16;
  assign duty16 = 16'(pwm_duty_reg);

  always_comb begin
    rd_mux = '0;
    unique case (bus.addr)
      2'd0: begin
        rd_mux[2:0]   = ctrl_reg;
        rd_mux[6:4]   = state_reg;
        rd_mux[8]     = irq_flag_reg;
        rd_mux[31:16] = duty16;
      end
      2'd1: rd_mux = 32'(period_reg);
      2'd2: rd_mux = 32'(duty_reg);
      default: rd_mux = {hold_reg, 16'(step_reg)};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             rdata_reg <= '0;
    else if (bus.rd_en)  rdata_reg <= rd_mux;
  end

  assign bus.rdata      = rdata_reg;
  assign bus.pwm_period = pwm_period_reg;
  assign bus.pwm_duty   = pwm_duty_reg;
  assign bus.pwm_load   = pwm_load_reg;
  assign bus.pwm_enable = pwm_enable_reg;
  assign bus.irq        = irq_flag_reg;

endmodule

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
Register-programmed controller that configures and sequences the SOC's PWM generator. Sits on the CPU memory-mapped IO bus beside the UART/LED IO. Drives period/duty/enable into the PWM core, either as a fixed manual duty or as an autonomous up/hold/down/hold "breathing" ramp. New values are committed only at PWM period boundaries, so the PWM pin never shows a glitched or partial cycle.

Parameters:
W, 16, width of period, duty and step values
PERIOD_RST, 1000, PERIOD register reset value (PWM clocks per period)

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous reset, active-high
wr_en  in  1  bus write strobe, 1 cycle
rd_en  in  1  bus read strobe, 1 cycle
addr  in  2  register index: 0 CTRL, 1 PERIOD, 2 DUTY, 3 STEP_HOLD
wdata  in  32  write data
rdata  out  32  read data, registered, valid cycle after rd_en
period_end  in  1  1-cycle pulse from PWM core at counter wrap
pwm_period  out  W  period value to PWM core
pwm_duty  out  W  duty value to PWM core
pwm_load  out  1  1-cycle strobe: PWM core latches pwm_period/pwm_duty
pwm_enable  out  1  PWM core run enable
irq  out  1  sequence-done interrupt (see Optional Feature)

Behaviour:
- Reset: pwm_period=PERIOD_RST, pwm_duty=0, pwm_load=0, pwm_enable=0, rdata=0, irq=0; state IDLE; all shadow registers 0 except PERIOD=PERIOD_RST.
- Registers: CTRL[0] EN, CTRL[1] MODE (0 manual, 1 ramp), CTRL[2] ONESHOT. PERIOD[W-1:0]. DUTY[W-1:0] = manual duty / ramp maximum. STEP_HOLD[W-1:0] = step, [31:16] = hold in periods.
- CTRL read: [2:0] config, [6:4] state code, [8] irq flag, [31:16] current duty (zero-extended if W<16).
- Other registers read back as written.
- Writes go to shadow registers only. Commit happens on period_end; outputs update the next edge, with pwm_load high that same cycle (1-cycle latency).
- If a write and period_end coincide, the commit uses the pre-write shadow value. The new value commits at the following period_end.
- EN 0->1: pwm_enable=1 next cycle, pwm_period/pwm_duty loaded immediately with one pwm_load pulse. State goes to MANUAL or RAMP_UP per MODE; ramp starts from duty 0.
- EN 1->0: next cycle pwm_enable=0, pwm_duty=0, state IDLE, hold counter cleared. No wait for period_end.
- States: IDLE(0), MANUAL(1), RAMP_UP(2), HOLD_HI(3), RAMP_DOWN(4), HOLD_LO(5). All transitions occur only on period_end, except the enable/disable transitions above.
- MANUAL: each period_end commits PERIOD and DUTY.
- RAMP_UP: duty += step, saturating at max. On reaching max, go to HOLD_HI.
- HOLD_HI: count hold periods, then RAMP_DOWN.
- RAMP_DOWN: duty -= step, saturating at 0. On reaching 0, go to HOLD_LO.
- HOLD_LO: after hold periods, go to RAMP_UP. If ONESHOT=1, instead go to IDLE with pwm_enable=0 and signal done.
- Boundaries:
  - step=0 is treated as 1.
  - hold=0 skips the hold state at the next period_end (one period at the extreme).
  - Ramp maximum = min(DUTY, PERIOD).
  - Arithmetic is W+1 bits internally; no wrap-around.
- MODE changed while enabled takes effect at the next period_end. Manual->ramp restarts at RAMP_UP from the current duty.
- RESET mid-sequence returns to reset values immediately (asynchronous).

Optional Feature:
PWM_RAMP_IRQ_EN.
- Defined: a sticky irq flag sets the cycle ONESHOT completes and when HOLD_LO is entered in continuous ramp mode. Writing CTRL with wdata[8]=1 clears it; set wins over a simultaneous clear. irq = flag.
- Undefined: the flag logic is absent, irq is tied 0 and CTRL[8] reads 0.

Test Plan:
- Reset pulse of 100 ns -> pwm_enable=0, pwm_duty=0, pwm_period=1000, rdata of CTRL = 0.
- Manual mode: PERIOD=100, DUTY=25, CTRL=1 -> next cycle pwm_load=1, duty 25. Write DUTY=60 -> duty stays 25 until the next period_end, then 60 with one pwm_load.
- Ramp: PERIOD=100, DUTY=40, step=10, hold=2, CTRL=0x3 -> per period_end duty 10,20,30,40, two holds at 40, then 30,20,10,0, two holds, repeat.
- Saturation/clamp: DUTY=250, PERIOD=100, step=30 -> duty 30,60,90,100 (never >100). step=0 -> increments of 1.
- Write DUTY in the same cycle as period_end -> old value committed, new value on the next period_end. Clear EN mid-RAMP_DOWN -> pwm_enable=0 and duty=0 the next cycle, state IDLE.
- With PWM_RAMP_IRQ_EN, ONESHOT=1 -> irq rises on return to IDLE. CTRL write with bit8=1 -> irq low next cycle. Without the macro, irq stays 0 throughout.
